// File: rtl/warmboot_pkg.sv
// -----------------------------------------------------------------------------
// warmboot_pkg
//   Shared types and helpers for the warm-boot sequencer.
//   - state_e  : sequencer FSM states
//   - cnt_w    : counter width able to hold the value v (0..v inclusive)
//   - in_reset : states during which the user core is held in reset
// -----------------------------------------------------------------------------
package warmboot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        BOOT = 3'd2,
        WAIT = 3'd3,
        HOLD = 3'd4
    } state_e;

    function automatic int cnt_w(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

    // ARM, BOOT and WAIT keep the user core quiet regardless of the stretch.
    function automatic logic in_reset(input state_e s);
        return (s == ARM) || (s == BOOT) || (s == WAIT);
    endfunction

endpackage

// File: rtl/io_debounce.sv
// -----------------------------------------------------------------------------
// io_debounce
//   Two-flop synchroniser followed by a stable-high count filter.
//   The output goes high once the synchronised level has been sampled high
//   for DEBOUNCE_CYCLES consecutive cycles and drops on the first low sample.
//
//   Ports
//     clk   : fabric clock
//     rst_n : synchronous active-low reset
//     raw   : asynchronous input pin
//     clean : registered, debounced level
// -----------------------------------------------------------------------------
module io_debounce
    import warmboot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    localparam int            CW   = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            count <= '0;
            clean <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            // Count saturates at LAST so a long press never wraps back to 0.
            if (!sync) begin
                count <= '0;
            end else if (count != LAST) begin
                count <= count + 1'b1;
            end
            clean <= sync && (count == LAST);
        end
    end

endmodule

// File: rtl/warmboot_sequencer.sv
// -----------------------------------------------------------------------------
// warmboot_sequencer
//   Turns a debounced request pin into a WARMBOOT reconfiguration: quiesces
//   the user core, validates the requested slot, issues a timed BOOT pulse,
//   and flags a timeout if the fabric never reconfigures. Also stretches the
//   fabric reset seen by the user core.
//
//   Ports
//     clk            : fabric clock
//     rst_n          : synchronous active-low reset
//     req_in         : raw boot request pin (active-high, asynchronous)
//     slot_in        : raw slot select pins (asynchronous)
//     fabric_reset_i : RESET from the WARMBOOT wrapper (active-high)
//     slot_o         : slot number to WARMBOOT.SLOT
//     boot_o         : boot strobe to WARMBOOT.BOOT
//     user_rst_o     : active-high reset to the user core
//     busy_o         : sequencer is not idle
//     err_o          : sticky error (invalid slot or timeout)
// -----------------------------------------------------------------------------
module warmboot_sequencer
    import warmboot_pkg::*;
#(
    parameter int SLOT_W          = 4,
    parameter int MAX_SLOT        = 3,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int QUIESCE_CYCLES  = 64,
    parameter int BOOT_PULSE      = 4,
    parameter int TIMEOUT_CYCLES  = 65536,
    parameter int RESET_STRETCH   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_in,
    input  logic [SLOT_W-1:0] slot_in,
    input  logic              fabric_reset_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              boot_o,
    output logic              user_rst_o,
    output logic              busy_o,
    output logic              err_o
);

    // One timer is shared by ARM, BOOT and WAIT, so it is sized for the
    // longest of the three intervals.
    localparam int TMAX_A = (QUIESCE_CYCLES > BOOT_PULSE) ? QUIESCE_CYCLES : BOOT_PULSE;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TW     = cnt_w(TMAX);
    localparam int SW     = cnt_w(RESET_STRETCH);

    localparam logic [TW-1:0]     QUIESCE_LAST = TW'(QUIESCE_CYCLES - 1);
    localparam logic [TW-1:0]     PULSE_LAST   = TW'(BOOT_PULSE - 1);
    localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0]     STRETCH_LOAD = SW'(RESET_STRETCH);
    localparam logic [SLOT_W-1:0] SLOT_LIMIT   = SLOT_W'(MAX_SLOT);

    logic              req_clean;
    logic              req_clean_d;
    logic              start;
    logic [SLOT_W-1:0] slot_meta;
    logic [SLOT_W-1:0] slot_sync;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_q_next;
    state_e            state;
    state_e            state_next;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_next;
    logic              err_next;
    logic [SW-1:0]     stretch;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_req_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (req_in),
        .clean(req_clean)
    );

    // Only the rising edge of the clean level starts a sequence, so a
    // request held high cannot retrigger after an abort or HOLD.
    assign start = req_clean && !req_clean_d;

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        err_next    = err_o;
        slot_q_next = slot_q;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (start) begin
                    slot_q_next = slot_sync;
                    if (slot_sync > SLOT_LIMIT) begin
                        err_next   = 1'b1;
                        state_next = HOLD;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ARM;
                    end
                end
            end
            ARM: begin
                if (fabric_reset_i) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == QUIESCE_LAST) begin
                    state_next = BOOT;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            BOOT: begin
                if (fabric_reset_i) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == PULSE_LAST) begin
                    state_next = WAIT;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            WAIT: begin
                // Fabric reset is checked first: a reconfiguration that lands
                // on the timeout cycle is a success, not an error.
                if (fabric_reset_i) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    err_next   = 1'b1;
                    state_next = HOLD;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            HOLD: begin
                timer_next = '0;
                if (!req_clean) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with
    // the state register and carry no combinational path from any input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            err_o       <= 1'b0;
            req_clean_d <= 1'b0;
            slot_meta   <= '0;
            slot_sync   <= '0;
            stretch     <= STRETCH_LOAD;
            slot_o      <= '0;
            boot_o      <= 1'b0;
            busy_o      <= 1'b0;
            user_rst_o  <= 1'b1;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            err_o       <= err_next;
            req_clean_d <= req_clean;
            slot_meta   <= slot_in;
            slot_sync   <= slot_meta;
            if (fabric_reset_i) begin
                stretch <= STRETCH_LOAD;
            end else if (stretch != '0) begin
                stretch <= stretch - 1'b1;
            end
            slot_o     <= in_reset(state_next) ? slot_q_next : '0;
            boot_o     <= (state_next == BOOT);
            busy_o     <= (state_next != IDLE);
            // fabric_reset_i is included so the stretch reload never leaves a
            // one-cycle gap when an abort drops the state back to IDLE.
            user_rst_o <= fabric_reset_i || (stretch != '0) || in_reset(state_next);
        end
    end

    // The latched slot is data only; it is qualified by the state everywhere
    // it is used, so it needs no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_q_next;
    end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_warmboot_sequencer
//   Directed bench for warmboot_sequencer with small timing parameters.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_warmboot_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_in;
    logic [3:0] slot_in;
    logic       fabric_reset_i;
    logic [3:0] slot_o;
    logic       boot_o;
    logic       user_rst_o;
    logic       busy_o;
    logic       err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    warmboot_sequencer #(
        .SLOT_W         (4),
        .MAX_SLOT       (3),
        .DEBOUNCE_CYCLES(8),
        .QUIESCE_CYCLES (4),
        .BOOT_PULSE     (2),
        .TIMEOUT_CYCLES (32),
        .RESET_STRETCH  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_in),
        .slot_in       (slot_in),
        .fabric_reset_i(fabric_reset_i),
        .slot_o        (slot_o),
        .boot_o        (boot_o),
        .user_rst_o    (user_rst_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raises the request just after an edge (that next edge is edge 0) and
    // steps to just after edge 10, where the FSM should have left IDLE.
    task automatic request(input logic [3:0] slot);
        slot_in = slot;
        req_in  = 1'b1;
        tick(10);
        check("pre_start_busy", int'(busy_o), 0);
        tick(1);
    endtask

    task automatic release_req();
        req_in = 1'b0;
        tick(6);
    endtask

    initial begin
        int seen;

        rst_n          = 1'b0;
        req_in         = 1'b0;
        slot_in        = 4'd0;
        fabric_reset_i = 1'b0;

        // Reset release and stretch
        tick(3);
        check("rst_slot", int'(slot_o), 0);
        check("rst_boot", int'(boot_o), 0);
        check("rst_user_rst", int'(user_rst_o), 1);
        check("rst_busy", int'(busy_o), 0);
        check("rst_err", int'(err_o), 0);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (user_rst_o) seen++;
            if (busy_o || boot_o || err_o || (slot_o != 4'd0)) seen += 100;
        end
        check("stretch_high_cycles", seen, 16);
        tick(1);
        check("stretch_end", int'(user_rst_o), 0);

        // Valid request to slot 2, accepted by a fabric reset in WAIT
        request(4'd2);
        check("valid_busy", int'(busy_o), 1);
        check("valid_slot", int'(slot_o), 2);
        check("valid_user_rst", int'(user_rst_o), 1);
        check("valid_boot_arm", int'(boot_o), 0);
        slot_in = 4'd7;
        tick(3);
        check("boot_before", int'(boot_o), 0);
        tick(1);
        check("boot_first", int'(boot_o), 1);
        check("slot_ignores_input", int'(slot_o), 2);
        tick(1);
        check("boot_second", int'(boot_o), 1);
        tick(1);
        check("boot_after", int'(boot_o), 0);
        check("wait_user_rst", int'(user_rst_o), 1);
        fabric_reset_i = 1'b1;
        tick(1);
        fabric_reset_i = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_err", int'(err_o), 0);
        check("abort_slot", int'(slot_o), 0);
        check("abort_user_rst", int'(user_rst_o), 1);
        tick(10);
        check("abort_no_restart", int'(busy_o), 0);
        check("abort_stretch", int'(user_rst_o), 1);
        release_req();
        tick(20);
        check("abort_stretch_end", int'(user_rst_o), 0);

        // Glitchy request never starts
        seen = 0;
        slot_in = 4'd1;
        req_in = 1'b1;
        for (int k = 0; k < 7; k++) begin tick(1); seen += int'(busy_o); end
        req_in = 1'b0;
        tick(1);
        seen += int'(busy_o);
        req_in = 1'b1;
        for (int k = 0; k < 7; k++) begin tick(1); seen += int'(busy_o); end
        req_in = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(1); seen += int'(busy_o); end
        check("glitch_busy", seen, 0);

        // Invalid slot goes straight to HOLD with an error
        request(4'd5);
        check("inv_err", int'(err_o), 1);
        check("inv_busy", int'(busy_o), 1);
        check("inv_slot", int'(slot_o), 0);
        seen = int'(boot_o);
        for (int k = 0; k < 10; k++) begin tick(1); seen += int'(boot_o); end
        check("inv_no_boot", seen, 0);
        check("inv_hold", int'(busy_o), 1);
        req_in = 1'b0;
        tick(3);
        check("hold_until_clean_low", int'(busy_o), 1);
        tick(1);
        check("hold_exit", int'(busy_o), 0);
        check("inv_err_sticky", int'(err_o), 1);
        tick(4);

        // Timeout, then a new valid request clears the error
        request(4'd1);
        check("to_err_cleared", int'(err_o), 0);
        check("to_slot", int'(slot_o), 1);
        tick(6);
        check("to_wait_boot", int'(boot_o), 0);
        check("to_wait_busy", int'(busy_o), 1);
        tick(31);
        check("to_err_early", int'(err_o), 0);
        tick(1);
        check("to_err_set", int'(err_o), 1);
        check("to_hold_busy", int'(busy_o), 1);
        check("to_hold_slot", int'(slot_o), 0);
        check("to_hold_user_rst", int'(user_rst_o), 0);
        release_req();
        check("to_idle", int'(busy_o), 0);
        check("to_err_sticky", int'(err_o), 1);
        request(4'd3);
        check("retry_err_cleared", int'(err_o), 0);
        check("retry_slot", int'(slot_o), 3);

        // Reset asserted while the boot pulse is high
        tick(4);
        check("rb_boot_high", int'(boot_o), 1);
        rst_n = 1'b0;
        tick(1);
        check("rb_boot", int'(boot_o), 0);
        check("rb_busy", int'(busy_o), 0);
        check("rb_slot", int'(slot_o), 0);
        check("rb_user_rst", int'(user_rst_o), 1);
        check("rb_err", int'(err_o), 0);
        rst_n  = 1'b1;
        req_in = 1'b0;
        tick(3);
        check("rb_stays_idle", int'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/warmboot_sequencer.md
# warmboot_sequencer

Parametrised warm-boot and reset sequencer for user designs on the FPGA fabric. It replaces hard-tied `SLOT`/`BOOT` inputs on the `WARMBOOT` primitive with a debounced, pin-driven reconfiguration request. It quiesces the user design, validates the slot, issues a timed boot pulse and reports timeout. It sits between the chip IOs, the `WARMBOOT` wrapper and the user core such as `servant`, and stretches the fabric reset seen by the core.

## Interface
- `SLOT_W`, 4, width of slot number.
- `MAX_SLOT`, 3, highest valid slot. Requests above it are rejected.
- `DEBOUNCE_CYCLES`, 1024, stable-high cycles required on the request pin (≥2).
- `QUIESCE_CYCLES`, 64, user reset held before the boot pulse (≥1).
- `BOOT_PULSE`, 4, cycles `boot_o` is high (≥1).
- `TIMEOUT_CYCLES`, 65536, wait for reconfiguration before flagging error.
- `RESET_STRETCH`, 16, minimum `user_rst_o` assertion after any reset source (≥1).
- `clk` in 1: fabric clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req_in` in 1: raw asynchronous boot request pin, active-high.
- `slot_in` in `SLOT_W`: raw asynchronous slot select pins.
- `fabric_reset_i` in 1: `RESET` output of the `WARMBOOT` wrapper, active-high.
- `slot_o` out `SLOT_W`: to `WARMBOOT.SLOT`.
- `boot_o` out 1: to `WARMBOOT.BOOT`.
- `user_rst_o` out 1: active-high reset to the user core.
- `busy_o` out 1: high in any state other than IDLE.
- `err_o` out 1: sticky error. Set on invalid slot or timeout.

## Operation
- **Input synchronisation.** `req_in` and `slot_in` each pass through two flops.
- **Debounce.** The `req_s` counter increments while the synchronised level is high and clears to 0 on any low sample. `req_clean` rises when the count reaches `DEBOUNCE_CYCLES-1` and falls on the first low sample.
- **Start event.** A start is the 0→1 edge of `req_clean`. A request held high produces exactly one start.
- **FSM states:** IDLE, ARM, BOOT, WAIT, HOLD.
  - **IDLE.** On start, latch the synchronised slot into `slot_q`.
    - If `slot_q > MAX_SLOT`: set `err_o` and go to HOLD.
    - Otherwise clear `err_o` and go to ARM.
  - **ARM.** `user_rst_o`=1 and `slot_o`=`slot_q`. Count `QUIESCE_CYCLES`, then go to BOOT.
  - **BOOT.** `boot_o`=1 for exactly `BOOT_PULSE` cycles, then go to WAIT.
  - **WAIT.** `boot_o`=0 and `user_rst_o`=1. If `TIMEOUT_CYCLES` elapse, set `err_o` and go to HOLD.
  - **HOLD.** Stay until `req_clean`=0, then go to IDLE.
- **Output hold.** `slot_o` holds `slot_q` from ARM through WAIT and returns to 0 in IDLE. `slot_in` changes after the latch are ignored.
- **Reset stretch.**
  - The stretch counter reloads to `RESET_STRETCH` on `rst_n`=0 or on any cycle `fabric_reset_i`=1.
  - `user_rst_o` = (counter≠0) OR state∈{ARM, BOOT, WAIT}.
- **`fabric_reset_i` during ARM/BOOT/WAIT.** This means the fabric accepted the reconfiguration. Abort to IDLE with no error.
- **Reset values (`rst_n`=0).**
  - Outputs: `slot_o`=0, `boot_o`=0, `user_rst_o`=1, `busy_o`=0, `err_o`=0.
  - Internal: state=IDLE, debounce count=0, synchroniser flops=0.
- **Reset mid-operation.** `rst_n` low at any point forces the reset values on the next edge. `boot_o` must never remain high.

## Timing
- **Request latency.** Take `req_in` high and stable before edge 0.
  - Synchronised level is high after edge 1.
  - `req_clean` is high after edge 1+`DEBOUNCE_CYCLES`.
  - State is ARM after edge 2+`DEBOUNCE_CYCLES`.
- **Boot pulse.** `boot_o` rises `QUIESCE_CYCLES` cycles after ARM entry and is high for `BOOT_PULSE` consecutive cycles.
- **Register timing.** All outputs are registered, with no combinational path from input to output.
- **Counter widths.** Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.
- **Simultaneous events.** If `fabric_reset_i` arrives on the same cycle as the timeout, `fabric_reset_i` wins and `err_o` is not set.
- **Start during stretch.** A start during an active stretch is accepted. The stretch still applies, and `user_rst_o` is the OR of both sources.

## Structure
- **`warmboot_pkg`:** `state_e` enum (IDLE, ARM, BOOT, WAIT, HOLD) and a `cnt_w` function wrapping `$clog2`.
- **Sub-module `io_debounce`:** two-flop synchroniser plus stable-count filter, parametrised by `DEBOUNCE_CYCLES`. Instantiated once for `req_in`.
- **Slot path:** `slot_in` uses only a synchroniser, because it is sampled at the start event.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=8, `QUIESCE_CYCLES`=4, `BOOT_PULSE`=2, `TIMEOUT_CYCLES`=32, `RESET_STRETCH`=16, `MAX_SLOT`=3.
- **Reset release.** `rst_n` low 3 cycles, then high → `user_rst_o`=1 for exactly 16 cycles after release. All other outputs stay 0.
- **Valid request.** `slot_in`=2, `req_in` high → ARM at edge 10, `slot_o`=2, `boot_o` high on exactly 2 cycles starting 4 cycles later. Then `fabric_reset_i` pulse → IDLE, `err_o`=0.
- **Glitchy request.** `req_in` high 7 cycles, low 1, high 7 → no start, `busy_o` stays 0.
- **Invalid slot.** `slot_in`=5 → `err_o`=1 and no `boot_o` pulse. HOLD until `req_in` drops, then IDLE.
- **Timeout.** Valid request with no `fabric_reset_i` → `err_o`=1 exactly 32 cycles after WAIT entry. The next valid request clears `err_o`.
- **Reset during boot.** `rst_n` low during BOOT → `boot_o`=0 and state IDLE on the next edge. `slot_o`=0.
